// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer between the 6502 core and the system bus.
// A CPU write to the DMA register stalls the CPU through RDY and copies one
// 256-byte page into the PPU OAM data port, one read/write pair per byte.
// Every source read is aligned to an even cycle (parity == 0), so the total
// stall is 513 or 514 cycles plus one per CPU write cycle seen while halting.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_din,
  output logic        cpu_rdy,
  output logic [15:0] bus_a,
  output logic [7:0]  bus_dout,
  output logic        bus_rw,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data;
  logic       parity;

  logic       trigger;
  logic       last_byte;

  // The trigger decodes only the CPU side, so the DMA's own $2004 writes can
  // never restart a transfer.
  assign trigger   = (cpu_rw == 1'b0) && (cpu_a == DMA_REG_ADDR);
  // The index is 8 bits wide, so the transfer length is a full page.
  assign last_byte = (idx == 8'(XFER_LEN - 1));

  // Next-state selection; HALT holds until the CPU is on a read cycle, since
  // the 6502 ignores RDY during writes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger) state_nxt = HALT;
      HALT:    if (cpu_rw) state_nxt = parity ? READ : ALIGN;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = last_byte ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state, transfer registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      data       <= 8'h00;
      parity     <= 1'b0;
      cpu_rdy    <= 1'b1;
      dma_active <= 1'b0;
    end else begin
      parity     <= ~parity;
      state      <= state_nxt;
      cpu_rdy    <= (state_nxt == IDLE);
      dma_active <= (state_nxt == READ) || (state_nxt == WRITE);
      case (state)
        IDLE: begin
          if (trigger) begin
            page <= cpu_dout;
            idx  <= 8'h00;
          end
        end
        READ:    data <= bus_din;
        WRITE:   idx  <= idx + 8'h01;
        default: ;
      endcase
    end
  end

  // Bus ownership mux: the CPU passes straight through unless the DMA is
  // actively reading the source page or writing OAM.
  always_comb begin
    bus_a    = cpu_a;
    bus_rw   = cpu_rw;
    bus_dout = cpu_dout;
    case (state)
      READ: begin
        bus_a    = {page, idx};
        bus_rw   = 1'b1;
        bus_dout = data;
      end
      WRITE: begin
        bus_a    = OAM_DATA_ADDR;
        bus_rw   = 1'b0;
        bus_dout = data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: a simple CPU driver, a page-addressed memory model
// and a transaction-level expectation of each DMA transfer.
module tb_oam_dma_ctrl;

  localparam logic [15:0] DMA_REG = 16'h4014;
  localparam logic [15:0] OAM_REG = 16'h2004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_a = 16'h8000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rw = 1'b1;
  logic [7:0]  bus_din;
  logic        cpu_rdy;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_rw;
  logic        dma_active;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [7:0]  mem_key = 8'hA5;
  logic [7:0]  mem_mix = 8'h00;
  logic [7:0]  oam_q[$];

  oam_dma_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_a      (cpu_a),
    .cpu_dout   (cpu_dout),
    .cpu_rw     (cpu_rw),
    .bus_din    (bus_din),
    .cpu_rdy    (cpu_rdy),
    .bus_a      (bus_a),
    .bus_dout   (bus_dout),
    .bus_rw     (bus_rw),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; its LSB is the expected parity of the cycle.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Memory: byte at address A is A[7:0] ^ key ^ (A[15:8] & mix).
  always_comb bus_din = bus_rw ? (bus_a[7:0] ^ mem_key ^ (bus_a[15:8] & mem_mix)) : 8'h00;

  function automatic logic [7:0] mem_byte(input logic [7:0] pg, input logic [7:0] i);
    return i ^ mem_key ^ (pg & mem_mix);
  endfunction

  // One bus cycle: drive CPU side after the falling edge, sample 1 ns later.
  task automatic tick(input logic [15:0] a, input logic rw, input logic [7:0] d, input logic r);
    @(negedge clk);
    cpu_a = a; cpu_rw = rw; cpu_dout = d; rst = r;
    #1;
    if (bus_rw == 1'b0 && bus_a == OAM_REG) oam_q.push_back(bus_dout);
  endtask

  task automatic test_reset;
    tick(16'h8000, 1'b1, 8'h00, 1'b1);
    tick(16'h8000, 1'b1, 8'h00, 1'b1);
    tick(16'h8000, 1'b1, 8'h00, 1'b0);
    checks++;
    if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", cpu_rdy); end
    checks++;
    if (dma_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", dma_active); end
    checks++;
    if (bus_a !== 16'h8000) begin failures++; $display("FAIL reset_bus_a got=%h exp=8000", bus_a); end
    checks++;
    if (bus_rw !== 1'b1) begin failures++; $display("FAIL reset_bus_rw got=%b exp=1", bus_rw); end
  endtask

  // Full transfer of page pg with nwr CPU write cycles after the trigger and
  // the CPU's first read (the last halt cycle) landing on parity halt_par.
  task automatic run_dma(input logic [7:0] pg, input int nwr, input logic halt_par, input string name);
    int base, total, stall, j, bad;
    logic hpar;
    logic [15:0] a, ea;
    logic [7:0] d, ed;
    logic rw, erw, erdy, eact;
    bit chk_d;
    for (int n = 0; n < 2; n++) begin
      if (((cyc + 2 + nwr) % 2) == int'(halt_par)) break;
      tick(16'h8000, 1'b1, 8'h00, 1'b0);
    end
    oam_q.delete();
    tick(DMA_REG, 1'b0, pg, 1'b0);
    checks++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      failures++; $display("FAIL %s_trigger_cycle rdy=%b act=%b exp rdy=1 act=0", name, cpu_rdy, dma_active);
    end
    hpar  = 1'((cyc + 1 + nwr) % 2);
    base  = nwr + 1 + ((hpar == 1'b0) ? 1 : 0);
    total = base + 512;
    stall = 0;
    for (int k = 0; k <= total; k++) begin
      if (k < nwr) begin a = {8'h03, 8'($urandom)}; rw = 1'b0; end
      else begin a = 16'h8000 | 16'($urandom); rw = 1'b1; end
      d = 8'($urandom);
      tick(a, rw, d, 1'b0);
      if (cpu_rdy === 1'b0) stall++;
      erdy = (k == total); eact = 1'b0; ea = a; erw = rw; ed = d; chk_d = 1'b1;
      if (k >= base && k < total) begin
        j = k - base; eact = 1'b1;
        if (j % 2 == 0) begin ea = {pg, 8'(j / 2)}; erw = 1'b1; chk_d = 1'b0; end
        else begin ea = OAM_REG; erw = 1'b0; ed = mem_byte(pg, 8'(j / 2)); end
      end
      checks++;
      if ({cpu_rdy, dma_active, bus_a, bus_rw} !== {erdy, eact, ea, erw} || (chk_d && bus_dout !== ed)) begin
        failures++;
        $display("FAIL %s_cycle%0d got rdy=%b act=%b a=%h rw=%b d=%h exp rdy=%b act=%b a=%h rw=%b d=%h(chk=%0d)",
                 name, k, cpu_rdy, dma_active, bus_a, bus_rw, bus_dout, erdy, eact, ea, erw, ed, chk_d);
      end
    end
    checks++;
    if (stall !== total) begin failures++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, stall, total); end
    bad = 0;
    if (oam_q.size() != 256) bad = 1;
    else for (int i = 0; i < 256; i++) if (oam_q[i] !== mem_byte(pg, 8'(i))) bad = 1;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL %s_oam_contents got_count=%0d exp_count=256", name, oam_q.size()); end
  endtask

  task automatic test_parity1;
    mem_key = 8'hA5; mem_mix = 8'h00;
    run_dma(8'h02, 0, 1'b1, "parity1");
  endtask

  task automatic test_parity0;
    mem_key = 8'hA5; mem_mix = 8'h00;
    run_dma(8'h02, 0, 1'b0, "parity0");
  endtask

  task automatic test_extra_writes;
    mem_key = 8'(($urandom)); mem_mix = 8'($urandom);
    run_dma(8'h07, 2, 1'($urandom), "extra_writes");
  endtask

  task automatic test_random;
    for (int t = 0; t < 4; t++) begin
      mem_key = 8'($urandom); mem_mix = 8'($urandom);
      run_dma(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back;
    mem_key = 8'h3C; mem_mix = 8'hFF;
    run_dma(8'h40, 0, 1'b1, "b2b_a");
    run_dma(8'h21, 1, 1'b1, "b2b_b");
  endtask

  task automatic test_reset_mid;
    int base;
    logic [15:0] a;
    mem_key = 8'h5A; mem_mix = 8'h00;
    oam_q.delete();
    tick(DMA_REG, 1'b0, 8'h05, 1'b0);
    base = 1 + ((((cyc + 1) % 2) == 0) ? 1 : 0);
    for (int k = 0; k < base + 129; k++) tick(16'h8000 | 16'($urandom), 1'b1, 8'($urandom), 1'b0);
    tick(16'h9000, 1'b1, 8'h00, 1'b1);
    checks++;
    if (bus_a !== OAM_REG || bus_rw !== 1'b0 || bus_dout !== (8'h40 ^ 8'h5A)) begin
      failures++; $display("FAIL rst_mid_write40 got a=%h rw=%b d=%h exp a=2004 rw=0 d=%h", bus_a, bus_rw, bus_dout, 8'h40 ^ 8'h5A);
    end
    a = 16'h8000 | 16'($urandom);
    tick(a, 1'b1, 8'h11, 1'b0);
    checks++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0 || bus_a !== a || bus_rw !== 1'b1) begin
      failures++; $display("FAIL rst_mid_after got rdy=%b act=%b a=%h rw=%b exp rdy=1 act=0 a=%h rw=1", cpu_rdy, dma_active, bus_a, bus_rw, a);
    end
    for (int k = 0; k < 20; k++) tick(16'h8000 | 16'($urandom), 1'b1, 8'($urandom), 1'b0);
    checks++;
    if (oam_q.size() != 65) begin failures++; $display("FAIL rst_mid_oam_count got=%0d exp=65", oam_q.size()); end
  endtask

  task automatic test_no_trigger;
    logic [15:0] a;
    int bad;
    bad = 0;
    tick(16'h4015, 1'b0, 8'h02, 1'b0);
    tick(DMA_REG, 1'b1, 8'h02, 1'b0);
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom);
      if (a == DMA_REG) a = 16'h4013;
      tick(a, 1'($urandom), 8'($urandom), 1'b0);
      tick(16'h8000, 1'b1, 8'h00, 1'b0);
      checks++;
      if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
        failures++; $display("FAIL no_trigger_%0d got rdy=%b act=%b exp rdy=1 act=0", k, cpu_rdy, dma_active);
      end
    end
    // Trigger coinciding with reset: reset wins.
    tick(DMA_REG, 1'b0, 8'h03, 1'b1);
    tick(16'h8000, 1'b1, 8'h00, 1'b0);
    checks++;
    if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
      failures++; $display("FAIL trigger_with_reset got rdy=%b act=%b exp rdy=1 act=0", cpu_rdy, dma_active);
    end
    tick(16'h8000, 1'b1, 8'h00, 1'b0);
    checks++;
    if (cpu_rdy !== 1'b1) begin failures++; $display("FAIL trigger_with_reset_next got rdy=%b exp=1", cpu_rdy); end
  endtask

  initial begin
    test_reset();
    test_parity1();
    test_parity0();
    test_extra_writes();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_no_trigger();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
